byteswap_chunk_sequencer: RTL and testbench



---
 rtl/byteswap_chunk_sequencer_if.sv | 39 +++
 rtl/byteswap_chunk_sequencer.sv | 151 +++++++++++++++
 tb/tb_byteswap_chunk_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byteswap_chunk_sequencer_if.sv
// Control/bus bundle between the kernel control slave, the chunk sequencer and the AXI masters.
// The master modport is the sequencer's view; the slave modport is the host/master side.
interface byteswap_chunk_sequencer_if #(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32
);
  logic                         ap_start;
  logic                         ap_idle;
  logic                         ap_done;
  logic                         ap_ready;
  logic [C_ADDR_WIDTH-1:0]      src_ptr;
  logic [C_ADDR_WIDTH-1:0]      dst_ptr;
  logic [C_XFER_SIZE_WIDTH-1:0] xfer_bytes;
  logic                         rd_ctrl_start;
  logic [C_ADDR_WIDTH-1:0]      rd_ctrl_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0] rd_ctrl_xfer_bytes;
  logic                         rd_ctrl_done;
  logic                         wr_ctrl_start;
  logic [C_ADDR_WIDTH-1:0]      wr_ctrl_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0] wr_ctrl_xfer_bytes;
  logic                         wr_ctrl_done;
  logic [C_XFER_SIZE_WIDTH-1:0] chunk_cnt;

  modport master (
    input  ap_start, src_ptr, dst_ptr, xfer_bytes, rd_ctrl_done, wr_ctrl_done,
    output ap_idle, ap_done, ap_ready,
    output rd_ctrl_start, rd_ctrl_addr_offset, rd_ctrl_xfer_bytes,
    output wr_ctrl_start, wr_ctrl_addr_offset, wr_ctrl_xfer_bytes,
    output chunk_cnt
  );

  modport slave (
    output ap_start, src_ptr, dst_ptr, xfer_bytes, rd_ctrl_done, wr_ctrl_done,
    input  ap_idle, ap_done, ap_ready,
    input  rd_ctrl_start, rd_ctrl_addr_offset, rd_ctrl_xfer_bytes,
    input  wr_ctrl_start, wr_ctrl_addr_offset, wr_ctrl_xfer_bytes,
    input  chunk_cnt
  );
endinterface

// File: rtl/byteswap_chunk_sequencer.sv
// Splits one kernel job into chunks of at most C_CHUNK_BYTES, launching the read and write
// masters together per chunk and advancing both pointers once both report completion.
module byteswap_chunk_sequencer #(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_CHUNK_BYTES     = 65536
) (
  input  logic                           ap_clk,
  input  logic                           areset,
  byteswap_chunk_sequencer_if.master     bus
);

  localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_CHUNK = C_XFER_SIZE_WIDTH'(C_CHUNK_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FIN
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic                         r_ap_start;
  logic [C_ADDR_WIDTH-1:0]      r_src;
  logic [C_ADDR_WIDTH-1:0]      r_dst;
  logic [C_XFER_SIZE_WIDTH-1:0] r_remaining;
  logic [C_XFER_SIZE_WIDTH-1:0] r_chunk;
  logic [C_XFER_SIZE_WIDTH-1:0] r_chunk_cnt;
  logic                         r_rd_seen;
  logic                         r_wr_seen;

  logic                         w_start_pulse;
  logic                         w_rd_seen;
  logic                         w_wr_seen;
  logic                         w_both;
  logic [C_XFER_SIZE_WIDTH-1:0] w_rem_after;
  logic [C_XFER_SIZE_WIDTH-1:0] w_chunk_after;
  logic [C_XFER_SIZE_WIDTH-1:0] w_chunk_first;

  always_comb begin
    w_start_pulse = bus.ap_start & ~r_ap_start;
    w_rd_seen     = r_rd_seen | bus.rd_ctrl_done;
    w_wr_seen     = r_wr_seen | bus.wr_ctrl_done;
    // Completion is recognised in the same cycle as the second done pulse.
    w_both        = (r_state == S_WAIT) && w_rd_seen && w_wr_seen;
    w_rem_after   = r_remaining - r_chunk;
    w_chunk_after = (w_rem_after > LP_CHUNK) ? LP_CHUNK : w_rem_after;
    w_chunk_first = (bus.xfer_bytes > LP_CHUNK) ? LP_CHUNK : bus.xfer_bytes;
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next            = r_state;
    bus.ap_idle       = 1'b0;
    bus.ap_done       = 1'b0;
    bus.ap_ready      = 1'b0;
    bus.rd_ctrl_start = 1'b0;
    bus.wr_ctrl_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.ap_idle = 1'b1;
        if (w_start_pulse) begin
          w_next = (bus.xfer_bytes == '0) ? S_FIN : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        bus.rd_ctrl_start = 1'b1;
        bus.wr_ctrl_start = 1'b1;
        w_next            = S_WAIT;
      end
      S_WAIT: begin
        if (w_both) begin
          w_next = (w_rem_after == '0) ? S_FIN : S_LAUNCH;
        end
      end
      S_FIN: begin
        bus.ap_done  = 1'b1;
        bus.ap_ready = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_ap_start  <= 1'b0;
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_chunk     <= '0;
      r_chunk_cnt <= '0;
      r_rd_seen   <= 1'b0;
      r_wr_seen   <= 1'b0;
    end else begin
      r_ap_start <= bus.ap_start;
      case (r_state)
        S_IDLE: begin
          if (w_start_pulse) begin
            r_src       <= bus.src_ptr;
            r_dst       <= bus.dst_ptr;
            r_remaining <= bus.xfer_bytes;
            r_chunk_cnt <= '0;
            if (bus.xfer_bytes != '0) begin
              r_chunk <= w_chunk_first;
            end
          end
        end
        S_LAUNCH: begin
          // Chunk length is registered on entry to LAUNCH so it is valid alongside the start pulse.
          r_rd_seen <= bus.rd_ctrl_done;
          r_wr_seen <= bus.wr_ctrl_done;
        end
        S_WAIT: begin
          if (w_both) begin
            r_src       <= r_src + C_ADDR_WIDTH'(r_chunk);
            r_dst       <= r_dst + C_ADDR_WIDTH'(r_chunk);
            r_remaining <= w_rem_after;
            r_chunk_cnt <= r_chunk_cnt + C_XFER_SIZE_WIDTH'(1);
            r_rd_seen   <= 1'b0;
            r_wr_seen   <= 1'b0;
            if (w_rem_after != '0) begin
              r_chunk <= w_chunk_after;
            end
          end else begin
            r_rd_seen <= w_rd_seen;
            r_wr_seen <= w_wr_seen;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rd_ctrl_addr_offset = r_src;
    bus.wr_ctrl_addr_offset = r_dst;
    bus.rd_ctrl_xfer_bytes  = r_chunk;
    bus.wr_ctrl_xfer_bytes  = r_chunk;
    bus.chunk_cnt           = r_chunk_cnt;
  end

endmodule

// File: tb/tb_byteswap_chunk_sequencer.sv
// Bench for the chunk sequencer: the expected launch list is derived from the job length by
// ceil-division, and masters are emulated with fixed or random done-pulse delays.
module tb_byteswap_chunk_sequencer;

  localparam int unsigned AW = 64;
  localparam int unsigned XW = 32;
  localparam int unsigned CB = 4096;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  byteswap_chunk_sequencer_if #(.C_ADDR_WIDTH(AW), .C_XFER_SIZE_WIDTH(XW)) bus ();

  byteswap_chunk_sequencer #(
    .C_ADDR_WIDTH     (AW),
    .C_XFER_SIZE_WIDTH(XW),
    .C_CHUNK_BYTES    (CB)
  ) dut (
    .ap_clk(clk),
    .areset(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want summary");
    $fatal(1, "watchdog");
  end

  // Runs one job and checks every launch, the no-early-advance window and the done pulse.
  task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [XW-1:0] xfer, input int rdd, input int wrd,
                         input bit rnd, input bit hold, input string tag);
    longint unsigned lx, n_chunks, remk;
    logic [AW-1:0]   e_src, e_dst;
    logic [XW-1:0]   e_len;
    int              dr, dw, dmax;
    lx       = 64'(xfer);
    n_chunks = (lx + CB - 1) / CB;
    @(negedge clk);
    bus.ap_start   = 1'b1;
    bus.src_ptr    = src;
    bus.dst_ptr    = dst;
    bus.xfer_bytes = xfer;
    @(negedge clk);
    if (!hold) bus.ap_start = 1'b0;
    n_vec++;
    if (bus.ap_idle !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after_start: got %b want 0", tag, bus.ap_idle);
    end
    for (longint unsigned k = 0; k < n_chunks; k++) begin
      remk  = lx - k * CB;
      e_src = src + AW'(k * CB);
      e_dst = dst + AW'(k * CB);
      e_len = XW'((remk > CB) ? CB : remk);
      n_vec++;
      if ({bus.rd_ctrl_start, bus.wr_ctrl_start} !== 2'b11) begin
        n_err++;
        $display("FAIL %s launch%0d_start: got rd=%b wr=%b want 1 1", tag, k,
                 bus.rd_ctrl_start, bus.wr_ctrl_start);
      end
      n_vec++;
      if (bus.rd_ctrl_addr_offset !== e_src || bus.wr_ctrl_addr_offset !== e_dst) begin
        n_err++;
        $display("FAIL %s launch%0d_addr: got rd=%h wr=%h want rd=%h wr=%h", tag, k,
                 bus.rd_ctrl_addr_offset, bus.wr_ctrl_addr_offset, e_src, e_dst);
      end
      n_vec++;
      if (bus.rd_ctrl_xfer_bytes !== e_len || bus.wr_ctrl_xfer_bytes !== e_len) begin
        n_err++;
        $display("FAIL %s launch%0d_len: got rd=%0d wr=%0d want %0d", tag, k,
                 bus.rd_ctrl_xfer_bytes, bus.wr_ctrl_xfer_bytes, e_len);
      end
      n_vec++;
      if (bus.chunk_cnt !== XW'(k)) begin
        n_err++;
        $display("FAIL %s launch%0d_cnt: got %0d want %0d", tag, k, bus.chunk_cnt, k);
      end
      dr   = rnd ? int'($urandom_range(0, 6)) : rdd;
      dw   = rnd ? int'($urandom_range(0, 6)) : wrd;
      dmax = (dr > dw) ? dr : dw;
      for (int t = 0; t <= dmax; t++) begin
        if (t > 0) begin
          @(negedge clk);
          n_vec++;
          if (bus.rd_ctrl_start !== 1'b0 || bus.wr_ctrl_start !== 1'b0 || bus.ap_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s wait%0d_t%0d: got start=%b%b done=%b want 00 0", tag, k, t,
                     bus.rd_ctrl_start, bus.wr_ctrl_start, bus.ap_done);
          end
        end
        if (hold && k == 0 && t == 1) bus.ap_start = 1'b0;
        if (hold && k == 0 && t == 2) bus.ap_start = 1'b1;
        bus.rd_ctrl_done = (t == dr);
        bus.wr_ctrl_done = (t == dw);
      end
      // Pulses during the launch cycle are remembered, but the one-cycle WAIT still follows.
      if (dmax == 0) begin
        @(negedge clk);
        bus.rd_ctrl_done = 1'b0;
        bus.wr_ctrl_done = 1'b0;
        n_vec++;
        if (bus.rd_ctrl_start !== 1'b0 || bus.ap_done !== 1'b0) begin
          n_err++;
          $display("FAIL %s wait%0d_after_launch_done: got start=%b done=%b want 0 0", tag, k,
                   bus.rd_ctrl_start, bus.ap_done);
        end
      end
      @(negedge clk);
      bus.rd_ctrl_done = 1'b0;
      bus.wr_ctrl_done = 1'b0;
    end
    n_vec++;
    if (bus.ap_done !== 1'b1 || bus.ap_ready !== 1'b1 || bus.rd_ctrl_start !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse: got done=%b ready=%b start=%b want 1 1 0", tag,
               bus.ap_done, bus.ap_ready, bus.rd_ctrl_start);
    end
    n_vec++;
    if (bus.chunk_cnt !== XW'(n_chunks)) begin
      n_err++;
      $display("FAIL %s chunk_cnt: got %0d want %0d", tag, bus.chunk_cnt, n_chunks);
    end
    @(negedge clk);
    n_vec++;
    if (bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0 || bus.ap_idle !== 1'b1) begin
      n_err++;
      $display("FAIL %s after_done: got done=%b ready=%b idle=%b want 0 0 1", tag,
               bus.ap_done, bus.ap_ready, bus.ap_idle);
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.ap_start     = 1'b0;
    bus.src_ptr      = '0;
    bus.dst_ptr      = '0;
    bus.xfer_bytes   = '0;
    bus.rd_ctrl_done = 1'b0;
    bus.wr_ctrl_done = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0 ||
        bus.rd_ctrl_start !== 1'b0 || bus.wr_ctrl_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got idle=%b done=%b ready=%b rs=%b ws=%b want 1 0 0 0 0",
               bus.ap_idle, bus.ap_done, bus.ap_ready, bus.rd_ctrl_start, bus.wr_ctrl_start);
    end
    n_vec++;
    if (bus.rd_ctrl_addr_offset !== '0 || bus.wr_ctrl_addr_offset !== '0 ||
        bus.rd_ctrl_xfer_bytes !== '0 || bus.wr_ctrl_xfer_bytes !== '0 || bus.chunk_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_data: got ra=%h wa=%h rl=%0d wl=%0d cnt=%0d want all 0",
               bus.rd_ctrl_addr_offset, bus.wr_ctrl_addr_offset, bus.rd_ctrl_xfer_bytes,
               bus.wr_ctrl_xfer_bytes, bus.chunk_cnt);
    end
    // ap_start already high when reset releases counts as a start.
    bus.ap_start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.ap_start = 1'b0;
    n_vec++;
    if (bus.ap_done !== 1'b1) begin
      n_err++;
      $display("FAIL reset_start_high: got done=%b want 1", bus.ap_done);
    end
    @(negedge clk);
    n_vec++;
    if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_start_high_idle: got idle=%b done=%b want 1 0", bus.ap_idle, bus.ap_done);
    end
  endtask

  task automatic test_multi_chunk();
    run_job(64'h1000, 64'h10_0000, 32'd10000, 20, 20, 1'b0, 1'b0, "multi");
  endtask

  task automatic test_zero_len();
    run_job(64'h5000, 64'h6000, 32'd0, 0, 0, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_done_order();
    run_job(64'h2_0000, 64'h3_0000, 32'd4096, 7, 2, 1'b0, 1'b0, "wr_first");
    run_job(64'h2_0000, 64'h3_0000, 32'd4096, 3, 3, 1'b0, 1'b0, "same_cycle");
    run_job(64'h2_0000, 64'h3_0000, 32'd4096, 1, 4, 1'b0, 1'b0, "rd_first");
  endtask

  task automatic test_start_held();
    int bad;
    bad = 0;
    run_job(64'hA000, 64'hB000, 32'd4096, 20, 20, 1'b0, 1'b1, "held");
    for (int c = 0; c < 470; c++) begin
      @(negedge clk);
      if (bus.ap_idle !== 1'b1 || bus.rd_ctrl_start !== 1'b0 || bus.ap_done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL held_no_restart: got %0d non-idle cycles want 0", bad);
    end
    n_vec++;
    if (bus.chunk_cnt !== XW'(1)) begin
      n_err++;
      $display("FAIL held_cnt: got %0d want 1", bus.chunk_cnt);
    end
    bus.ap_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_wrap();
    run_job(64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_E800, 32'd8192, 2, 5, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_reset_midjob();
    int bad;
    bad = 0;
    @(negedge clk);
    bus.ap_start   = 1'b1;
    bus.src_ptr    = 64'h4_0000;
    bus.dst_ptr    = 64'h8_0000;
    bus.xfer_bytes = 32'd10000;
    @(negedge clk);
    bus.ap_start = 1'b0;
    @(negedge clk);
    bus.rd_ctrl_done = 1'b1;
    bus.wr_ctrl_done = 1'b1;
    @(negedge clk);
    bus.rd_ctrl_done = 1'b0;
    bus.wr_ctrl_done = 1'b0;
    n_vec++;
    if (bus.rd_ctrl_start !== 1'b1 || bus.rd_ctrl_addr_offset !== 64'h4_1000) begin
      n_err++;
      $display("FAIL abort_chunk2_launch: got start=%b addr=%h want 1 0000000000041000",
               bus.rd_ctrl_start, bus.rd_ctrl_addr_offset);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.rd_ctrl_start !== 1'b0 ||
        bus.rd_ctrl_addr_offset !== '0 || bus.wr_ctrl_addr_offset !== '0 ||
        bus.rd_ctrl_xfer_bytes !== '0 || bus.chunk_cnt !== '0) begin
      n_err++;
      $display("FAIL abort_async: got idle=%b done=%b start=%b ra=%h wa=%h len=%0d cnt=%0d want 1 0 0 0 0 0 0",
               bus.ap_idle, bus.ap_done, bus.rd_ctrl_start, bus.rd_ctrl_addr_offset,
               bus.wr_ctrl_addr_offset, bus.rd_ctrl_xfer_bytes, bus.chunk_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.rd_ctrl_done = 1'b1;
    @(negedge clk);
    bus.rd_ctrl_done = 1'b0;
    bus.wr_ctrl_done = 1'b1;
    @(negedge clk);
    bus.wr_ctrl_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.ap_idle !== 1'b1 || bus.rd_ctrl_start !== 1'b0 || bus.ap_done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abort_late_done: got %0d non-idle cycles want 0", bad);
    end
    run_job(64'h7_0000, 64'h9_0000, 32'd5000, 4, 1, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    logic [AW-1:0] s, d;
    logic [XW-1:0] x;
    for (int j = 0; j < 12; j++) begin
      s = {$urandom, $urandom};
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       x = XW'($urandom_range(1, CB));
        1:       x = XW'(CB * $urandom_range(1, 3));
        2:       x = XW'($urandom_range(1, CB * 4));
        default: x = XW'(CB * $urandom_range(1, 2) + $urandom_range(1, 63));
      endcase
      run_job(s, d, x, 0, 0, 1'b1, 1'b0, $sformatf("rand%0d", j));
    end
  endtask

  initial begin
    test_reset();
    test_multi_chunk();
    test_zero_len();
    test_done_order();
    test_start_held();
    test_addr_wrap();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
